// File: rtl/pwr_seq_master.sv
// Power-sequencing bus master: writes the power-down bit of each peripheral in turn on sleep, clears them in reverse on wake.
// Define PWRSEQ_TIMEOUT_EN to abandon a sequence (and set sticky err) when ready never arrives.
module pwr_seq_master #(
    parameter int   DATA_W  = 32,
    parameter int   N_TGT   = 4,
    parameter int   TGT_W   = 2,
    parameter logic PD_ADDR = 1'b0,
    parameter int   GAP_CYC = 16,
    parameter int   TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sleep_req,
    input  logic              i_wake_req,
    output logic              o_valid,
    output logic [TGT_W-1:0]  o_tgt,
    output logic              o_address,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wstrb,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_asleep,
    output logic              o_err
);
    // state  | meaning
    // S_IDLE | waiting for an applicable sleep/wake request
    // S_REQ  | valid held high until ready (or timeout)
    // S_GAP  | settling gap before the next peripheral
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    localparam logic [TGT_W-1:0] LAST_TGT = TGT_W'(N_TGT - 1);
    // A zero gap still costs one cycle, so the load value saturates at 0.
    localparam logic [7:0]       GAP_LOAD = (GAP_CYC > 1) ? 8'(GAP_CYC - 1) : 8'd0;

    state_t           r_state, w_state_nx;
    logic             r_dir, w_dir_nx;
    logic [TGT_W-1:0] r_tgt, w_tgt_nx;
    logic [7:0]       r_gap_cnt, w_gap_cnt_nx;
    logic             r_valid, w_valid_nx;
    logic             r_asleep, w_asleep_nx;
    logic             r_addr, r_wd0, r_busy;
    logic             w_last, w_go_sleep, w_go_wake;
`ifdef PWRSEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LOAD = (TIMEOUT > 1) ? 8'(TIMEOUT - 1) : 8'd0;
    logic [7:0]       r_to_cnt, w_to_cnt_nx;
    logic             r_err, w_err_nx;
`endif

    assign w_go_sleep = i_sleep_req & ~r_asleep;
    assign w_go_wake  = i_wake_req & r_asleep;
    assign w_last     = r_dir ? (r_tgt == LAST_TGT) : (r_tgt == '0);

    always_comb begin
        w_state_nx   = r_state;
        w_dir_nx     = r_dir;
        w_tgt_nx     = r_tgt;
        w_gap_cnt_nx = r_gap_cnt;
        w_valid_nx   = r_valid;
        w_asleep_nx  = r_asleep;
`ifdef PWRSEQ_TIMEOUT_EN
        w_to_cnt_nx  = r_to_cnt;
        w_err_nx     = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_valid_nx = 1'b0;
                if (w_go_sleep || w_go_wake) begin
                    w_state_nx = S_REQ;
                    w_valid_nx = 1'b1;
                    w_dir_nx   = w_go_sleep;
                    w_tgt_nx   = w_go_sleep ? '0 : LAST_TGT;
`ifdef PWRSEQ_TIMEOUT_EN
                    w_to_cnt_nx = TO_LOAD;
                    w_err_nx    = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (i_ready) begin
                    w_valid_nx = 1'b0;
                    if (w_last) begin
                        w_state_nx  = S_IDLE;
                        w_asleep_nx = ~r_asleep;
                    end else begin
                        w_state_nx   = S_GAP;
                        w_gap_cnt_nx = GAP_LOAD;
                    end
                end
`ifdef PWRSEQ_TIMEOUT_EN
                else if (r_to_cnt == 8'd0) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = S_IDLE;
                    w_err_nx   = 1'b1;
                end else begin
                    w_to_cnt_nx = r_to_cnt - 8'd1;
                end
`endif
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_nx = S_REQ;
                    w_valid_nx = 1'b1;
                    w_tgt_nx   = r_dir ? (r_tgt + TGT_W'(1)) : (r_tgt - TGT_W'(1));
`ifdef PWRSEQ_TIMEOUT_EN
                    w_to_cnt_nx = TO_LOAD;
`endif
                end else begin
                    w_gap_cnt_nx = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // Bus-side outputs are registered from next-state values so they never glitch.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_tgt     <= '0;
            r_gap_cnt <= 8'd0;
            r_valid   <= 1'b0;
            r_asleep  <= 1'b0;
            r_addr    <= 1'b0;
            r_wd0     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_dir     <= w_dir_nx;
            r_tgt     <= w_tgt_nx;
            r_gap_cnt <= w_gap_cnt_nx;
            r_valid   <= w_valid_nx;
            r_asleep  <= w_asleep_nx;
            r_addr    <= w_valid_nx & PD_ADDR;
            r_wd0     <= w_valid_nx & w_dir_nx;
            r_busy    <= (w_state_nx != S_IDLE);
        end
    end

`ifdef PWRSEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_to_cnt <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nx;
            r_err    <= w_err_nx;
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_valid   = r_valid;
    assign o_wstrb   = r_valid;
    assign o_tgt     = r_tgt;
    assign o_address = r_addr;
    assign o_wdata   = {{(DATA_W-1){1'b0}}, r_wd0};
    assign o_busy    = r_busy;
    assign o_asleep  = r_asleep;
endmodule

// File: tb/tb_pwr_seq_master.sv
// Self-checking bench for pwr_seq_master: a default instance (4 targets, 16-cycle gap) and a small one (2 targets, zero gap).
// Expected writes and edge numbers come from the sequencing rules, not from the RTL structure.
module tb_pwr_seq_master;
    localparam int   N1 = 4, G1 = 16, N2 = 2, G2 = 0;
    localparam logic PD1 = 1'b0, PD2 = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic s1, w1, rdy1, v1, a1, ws1, b1, as1, e1;
    logic [1:0]  t1;
    logic [31:0] d1;
    logic s2, w2, rdy2, v2, a2, ws2, b2, as2, e2;
    logic [0:0]  t2;
    logic [31:0] d2;

    int checks = 0, errors = 0;
    int rmode = 0;
    bit sel = 1'b0;
    bit exp_asleep [2];
    int acc_e[$], acc_t[$], acc_d[$], acc_a[$], rise_e[$], vs[$];
    int done_e, stab_err;
    logic b0_busy, b0_err;

    pwr_seq_master #(.DATA_W(32), .N_TGT(N1), .TGT_W(2), .PD_ADDR(PD1), .GAP_CYC(G1), .TIMEOUT(255)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(s1), .i_wake_req(w1), .o_valid(v1), .o_tgt(t1),
        .o_address(a1), .o_wdata(d1), .o_wstrb(ws1), .i_ready(rdy1), .o_busy(b1), .o_asleep(as1), .o_err(e1));

    pwr_seq_master #(.DATA_W(32), .N_TGT(N2), .TGT_W(1), .PD_ADDR(PD2), .GAP_CYC(G2), .TIMEOUT(255)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(s2), .i_wake_req(w2), .o_valid(v2), .o_tgt(t2),
        .o_address(a2), .o_wdata(d2), .o_wstrb(ws2), .i_ready(rdy2), .o_busy(b2), .o_asleep(as2), .o_err(e2));

    // Responders: mode 0 registers ready from valid, mode 1 random ready, mode 2 never ready.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy1 <= 1'b0;
            rdy2 <= 1'b0;
        end else if (rmode == 0) begin
            rdy1 <= v1;
            rdy2 <= v2;
        end else if (rmode == 1) begin
            rdy1 <= 1'($urandom_range(0, 1));
            rdy2 <= 1'($urandom_range(0, 1));
        end else begin
            rdy1 <= 1'b0;
            rdy2 <= 1'b0;
        end
    end

    logic m_valid, m_ready, m_addr, m_busy, m_asleep, m_err;
    logic [1:0]  m_tgt;
    logic [31:0] m_wdata;
    assign m_valid  = sel ? v2 : v1;
    assign m_ready  = sel ? rdy2 : rdy1;
    assign m_addr   = sel ? a2 : a1;
    assign m_busy   = sel ? b2 : b1;
    assign m_asleep = sel ? as2 : as1;
    assign m_err    = sel ? e2 : e1;
    assign m_tgt    = sel ? {1'b0, t2} : t1;
    assign m_wdata  = sel ? d2 : d1;

    function automatic int f_n(bit s);
        return s ? N2 : N1;
    endfunction
    function automatic int f_gap(bit s);
        int g = s ? G2 : G1;
        return (g < 1) ? 1 : g;
    endfunction
    function automatic int f_pd(bit s);
        return s ? int'(PD2) : int'(PD1);
    endfunction
    function automatic int f_tgt(bit s, bit sl, int k);
        return sl ? k : f_n(s) - 1 - k;
    endfunction

    task automatic drive_req(input bit sr, input bit wr);
        if (sel) begin s2 = sr; w2 = wr; end
        else begin s1 = sr; w1 = wr; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        s1 = 0; w1 = 0; s2 = 0; w2 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_asleep[0] = 1'b0;
        exp_asleep[1] = 1'b0;
    endtask

    task automatic idle_watch(input int n, output int nv);
        nv = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_valid) nv++;
        end
    endtask

    // Issues a request at edge 0 and records every write until busy falls (edge numbers relative to the request edge).
    task automatic run_seq(input bit sr, input bit wr, input int maxc, input int poke);
        bit prev_v = 1'b0;
        int hold_t = 0, hold_d = 0;
        acc_e.delete(); acc_t.delete(); acc_d.delete(); acc_a.delete(); rise_e.delete(); vs.delete();
        done_e = -1;
        stab_err = 0;
        @(negedge clk);
        drive_req(sr, wr);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0);
        b0_busy = m_busy;
        b0_err  = m_err;
        for (int e = 1; e <= maxc; e++) begin
            @(negedge clk);
            if (e == poke) drive_req(1'b1, 1'b1);
            else drive_req(1'b0, 1'b0);
            vs.push_back(int'(m_valid));
            if (m_valid && !prev_v) begin
                rise_e.push_back(e - 1);
                hold_t = int'(m_tgt);
                hold_d = int'(m_wdata);
            end else if (m_valid && (int'(m_tgt) != hold_t || int'(m_wdata) != hold_d)) begin
                stab_err++;
            end
            if (m_valid && m_ready) begin
                acc_e.push_back(e);
                acc_t.push_back(int'(m_tgt));
                acc_d.push_back(int'(m_wdata));
                acc_a.push_back(int'(m_addr));
            end
            prev_v = m_valid;
            @(posedge clk);
            #1;
            if (!m_busy) begin
                done_e = e;
                break;
            end
        end
        drive_req(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({v1, t1, a1, d1, ws1, b1, as1, e1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {v1, t1, a1, d1, ws1, b1, as1, e1});
        end
        checks++;
        if ({v2, t2, a2, d2, ws2, b2, as2, e2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected 0", {v2, t2, a2, d2, ws2, b2, as2, e2});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({v1, b1, v2, b2} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {v1, b1, v2, b2});
        end
    endtask

    // Full sequence against a 1-cycle-ready responder: exact edges and valid pattern.
    task automatic test_timed_seq(input bit s, input bit sl);
        int n, p, last, bad;
        sel = s;
        rmode = 0;
        n = f_n(s);
        p = 2 + f_gap(s);
        last = 2 + (n - 1) * p;
        run_seq(sl, !sl, 200, -1);
        checks++;
        if (b0_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_start: got %b expected 1", b0_busy);
        end
        checks++;
        if (acc_e.size() != n) begin
            errors++;
            $display("FAIL write_count: got %0d expected %0d", acc_e.size(), n);
        end
        for (int k = 0; k < acc_e.size() && k < rise_e.size(); k++) begin
            checks++;
            if (acc_t[k] != f_tgt(s, sl, k) || acc_d[k] != int'(sl) || acc_a[k] != f_pd(s)) begin
                errors++;
                $display("FAIL write_content[%0d]: got tgt=%0d wdata=%0d addr=%0d expected tgt=%0d wdata=%0d addr=%0d",
                         k, acc_t[k], acc_d[k], acc_a[k], f_tgt(s, sl, k), int'(sl), f_pd(s));
            end
            checks++;
            if (acc_e[k] != 2 + k * p || rise_e[k] != k * p) begin
                errors++;
                $display("FAIL write_timing[%0d]: got rise=%0d accept=%0d expected rise=%0d accept=%0d",
                         k, rise_e[k], acc_e[k], k * p, 2 + k * p);
            end
        end
        bad = 0;
        for (int i = 0; i < vs.size(); i++)
            if (vs[i] != (((i % p) < 2) ? 1 : 0)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL valid_pattern: got %0d wrong cycles expected 0", bad);
        end
        checks++;
        if (done_e != last) begin
            errors++;
            $display("FAIL done_edge: got %0d expected %0d", done_e, last);
        end
        checks++;
        if (m_asleep !== sl || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL asleep_at_done: got asleep=%b valid=%b expected asleep=%b valid=0", m_asleep, m_valid, sl);
        end
        exp_asleep[s] = sl;
    endtask

    task automatic test_requests();
        int nv, poke, bad;
        sel = 1'b0;
        rmode = 0;
        @(negedge clk);
        drive_req(1'b0, 1'b1);
        @(negedge clk);
        drive_req(1'b0, 1'b0);
        idle_watch(20, nv);
        checks++;
        if (nv != 0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL wake_while_awake: got %0d writes busy=%b expected 0", nv, m_busy);
        end
        run_seq(1'b1, 1'b0, 200, -1);
        exp_asleep[0] = 1'b1;
        checks++;
        if (m_asleep !== 1'b1) begin
            errors++;
            $display("FAIL sleep_done: got asleep=%b expected 1", m_asleep);
        end
        @(negedge clk);
        drive_req(1'b1, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 1'b0);
        idle_watch(20, nv);
        checks++;
        if (nv != 0 || m_asleep !== 1'b1) begin
            errors++;
            $display("FAIL sleep_while_asleep: got %0d writes asleep=%b expected 0 writes asleep=1", nv, m_asleep);
        end
        poke = $urandom_range(5, 50);
        run_seq(1'b0, 1'b1, 200, poke);
        bad = 0;
        for (int k = 0; k < acc_e.size(); k++)
            if (acc_t[k] != f_tgt(0, 0, k) || acc_d[k] != 0) bad++;
        checks++;
        if (acc_e.size() != N1 || bad != 0 || done_e != 56 || m_asleep !== 1'b0) begin
            errors++;
            $display("FAIL req_while_busy: got writes=%0d bad=%0d done=%0d asleep=%b expected %0d 0 56 0",
                     acc_e.size(), bad, done_e, m_asleep, N1);
        end
        idle_watch(20, nv);
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL no_queued_req: got %0d writes expected 0", nv);
        end
        run_seq(1'b1, 1'b1, 200, -1);
        checks++;
        if (acc_e.size() != N1 || acc_d[0] != 1 || acc_t[0] != 0 || m_asleep !== 1'b1) begin
            errors++;
            $display("FAIL both_req_awake: got writes=%0d asleep=%b expected %0d writes asleep=1", acc_e.size(), m_asleep, N1);
        end
        run_seq(1'b0, 1'b1, 200, -1);
        checks++;
        if (m_asleep !== 1'b0) begin
            errors++;
            $display("FAIL wake_restore: got asleep=%b expected 0", m_asleep);
        end
        exp_asleep[0] = 1'b0;
    endtask

    // Random responder latency, random instance and idle spacing (including back-to-back).
    task automatic test_random();
        bit s, sl;
        int n, bad;
        for (int it = 0; it < 10; it++) begin
            s = 1'($urandom_range(0, 1));
            sel = s;
            rmode = 1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sl = !exp_asleep[s];
            n = f_n(s);
            run_seq(sl, !sl, 1000, -1);
            bad = 0;
            for (int k = 0; k < acc_e.size(); k++) begin
                if (acc_t[k] != f_tgt(s, sl, k) || acc_d[k] != int'(sl) || acc_a[k] != f_pd(s)) bad++;
                if (k + 1 < rise_e.size() && rise_e[k + 1] - acc_e[k] != f_gap(s)) bad++;
            end
            checks++;
            if (acc_e.size() != n || rise_e.size() != n || bad != 0 || stab_err != 0) begin
                errors++;
                $display("FAIL random_seq[%0d]: got writes=%0d rises=%0d bad=%0d unstable=%0d expected %0d %0d 0 0",
                         it, acc_e.size(), rise_e.size(), bad, stab_err, n, n);
            end
            checks++;
            if (acc_e.size() == 0 || done_e != acc_e[acc_e.size() - 1] || m_asleep !== sl) begin
                errors++;
                $display("FAIL random_done[%0d]: got done=%0d asleep=%b expected last accept, asleep=%b", it, done_e, m_asleep, sl);
            end
            exp_asleep[s] = sl;
        end
    endtask

    task automatic test_timeout();
        int nvh;
        apply_reset();
        sel = 1'b0;
        rmode = 2;
`ifdef PWRSEQ_TIMEOUT_EN
        run_seq(1'b1, 1'b0, 400, -1);
        nvh = vs.sum();
        checks++;
        if (done_e != 255 || nvh != 255 || acc_e.size() != 0) begin
            errors++;
            $display("FAIL timeout_drop: got done=%0d valid_cycles=%0d writes=%0d expected 255 255 0", done_e, nvh, acc_e.size());
        end
        checks++;
        if (m_err !== 1'b1 || m_asleep !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got err=%b asleep=%b valid=%b expected 1 0 0", m_err, m_asleep, m_valid);
        end
        rmode = 0;
        run_seq(1'b1, 1'b0, 200, -1);
        checks++;
        if (b0_err !== 1'b0 || m_asleep !== 1'b1) begin
            errors++;
            $display("FAIL err_cleared: got err=%b asleep=%b expected 0 1", b0_err, m_asleep);
        end
        exp_asleep[0] = 1'b1;
`else
        run_seq(1'b1, 1'b0, 300, -1);
        nvh = vs.sum();
        checks++;
        if (done_e != -1 || nvh != 300 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_forever: got done=%0d valid_cycles=%0d err=%b expected -1 300 0", done_e, nvh, m_err);
        end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int nv;
        apply_reset();
        sel = 1'b0;
        rmode = 0;
        @(negedge clk);
        drive_req(1'b1, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid && m_tgt == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_tgt2: got no write to tgt 2 expected one within 100 cycles");
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({v1, t1, a1, d1, ws1, b1, as1, e1} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {v1, t1, a1, d1, ws1, b1, as1, e1});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_asleep[0] = 1'b0;
        exp_asleep[1] = 1'b0;
        idle_watch(40, nv);
        checks++;
        if (nv != 0 || m_asleep !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_quiet: got writes=%0d asleep=%b busy=%b expected 0 0 0", nv, m_asleep, m_busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        s1 = 0; w1 = 0; s2 = 0; w2 = 0;
        exp_asleep[0] = 1'b0;
        exp_asleep[1] = 1'b0;
        test_reset();
        test_timed_seq(1'b0, 1'b1);
        test_timed_seq(1'b0, 1'b0);
        test_requests();
        test_timed_seq(1'b1, 1'b1);
        test_timed_seq(1'b1, 1'b0);
        test_random();
        test_timeout();
        test_reset_mid();
        test_timed_seq(1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwr_seq_master.md
# pwr_seq_master

Power-sequencing bus initiator for the energy-management subsystem. It drives the peripheral CPU-style write interface (valid/address/wdata/wstrb/ready) as a master. On a sleep request it writes the power-down register of each analog peripheral in turn, with a programmable settling gap between writes. On a wake request it clears them in reverse order. It sits beside the CPU on the peripheral interconnect, which routes each write by the `tgt` index.

## Interface
- `DATA_W`, 32: write data width.
- `N_TGT`, 4: number of peripherals sequenced (≥1).
- `TGT_W`, 2: width of `tgt` (≥ clog2(N_TGT), min 1).
- `PD_ADDR`, 1'b0: register address of the power-down bit in each peripheral.
- `GAP_CYC`, 16: settling cycles between consecutive writes (8-bit counter).
- `TIMEOUT`, 255: max cycles `valid` waits for `ready` (only with timeout feature; 8-bit counter).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sleep_req`  in  1  start power-down sequence (sampled when idle).
- `wake_req`  in  1  start power-up sequence (sampled when idle).
- `valid`  out  1  write request to peripheral.
- `tgt`  out  TGT_W  index of addressed peripheral.
- `address`  out  1  always `PD_ADDR` while `valid`; 0 otherwise.
- `wdata`  out  DATA_W  bit0 = power-down value, other bits 0.
- `wstrb`  out  1  1 while `valid` (write), 0 otherwise.
- `ready`  in  1  peripheral accept.
- `busy`  out  1  sequence in progress.
- `asleep`  out  1  all peripherals powered down.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, GAP.
- IDLE: accept `sleep_req` only if `asleep`=0. Accept `wake_req` only if `asleep`=1. A non-applicable request is ignored. If both requests are high, the applicable one wins. A start clears `err`.
- Sleep sequence: `tgt` 0,1,…,N_TGT-1, `wdata`=1. Wake sequence: `tgt` N_TGT-1,…,0, `wdata`=0.
- REQ: `valid`=1, `wstrb`=1. `tgt`, `address` and `wdata` stay stable until accept.
- Accept happens at the edge where `valid`=1 and `ready`=1 are sampled. At that edge `valid` goes to 0.
  - If this was the last step: go to IDLE and toggle `asleep`.
  - Otherwise: go to GAP and load the counter.
- GAP: `valid` stays low for max(GAP_CYC,1) cycles, then step the index and return to REQ.
- Requests arriving while `busy` are ignored; no queuing.
- All outputs are registered.
- `busy` = (state ≠ IDLE).

## Timing
- Reset (`rst`=0): immediately and asynchronously, `valid`=0, `tgt`=0, `address`=0, `wdata`=0, `wstrb`=0, `busy`=0, `asleep`=0, `err`=0, state IDLE.
- Reset during a sequence aborts it. No further writes are issued, and `asleep` returns to 0 regardless of the peripherals' state.
- A request sampled at edge 0 raises `valid` and `busy` after edge 0.
- With a peripheral that registers `ready` ≤ `valid` (1-cycle latency), `valid` is high for exactly 2 cycles per step.
- Step period = 2 + GAP_CYC cycles. No gap follows the last step.
- Defaults (N_TGT=4, GAP_CYC=16): the last accept is at edge 56 after the request edge. `asleep` and `busy` change after edge 56.
- Back-to-back: a new request can be sampled at the edge following the return to IDLE.
- `ready` seen while `valid`=0 is ignored.

## Configuration
- `PWRSEQ_TIMEOUT_EN` defined: a counter runs in REQ. If `ready` has not been sampled high after TIMEOUT cycles of `valid`, the block:
  - drops `valid`;
  - sets `err`=1 (sticky);
  - returns to IDLE with `asleep` unchanged; the remaining steps are skipped.
- `PWRSEQ_TIMEOUT_EN` undefined: REQ waits for `ready` indefinitely. `err` is tied to 0 and no counter is synthesized.

## Test plan
- Sleep with defaults and a 1-cycle-ready responder model → 4 writes, `tgt` 0,1,2,3, `wdata`=1, `address`=PD_ADDR, 16-cycle gaps, `asleep`=1 after edge 56.
- Wake after sleep → `tgt` 3,2,1,0, `wdata`=0, `asleep`=0 after edge 56, `busy` low at the same edge.
- `sleep_req` while `asleep`=1; `wake_req` while busy; both high in IDLE while awake → respectively no write, request ignored, sleep sequence starts.
- GAP_CYC=0, N_TGT=2, 1-cycle-ready responder → `valid` pattern 1,1,0,1,1,0; sleep completes at edge 5.
- Responder that never asserts `ready`, with `PWRSEQ_TIMEOUT_EN`, TIMEOUT=255 → `valid` drops after 255 cycles, `err`=1, `asleep`=0. Next `sleep_req` clears `err`.
- Assert `rst` low during `tgt`=2 of a sleep sequence → all outputs 0 immediately. After release, no write occurs until a new request.
